// File: rtl/pc_flow_sequencer_pkg.sv
// Shared encodings for the PC-flow sequencer: opcode/funct constants, datapath select
// encodings, the sequencer state encoding and the PC-altering instruction classes.
package pc_flow_sequencer_pkg;

    localparam int OP_W  = 6;
    localparam int SRC_W = 3;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OP_W-1:0] OP_J     = 6'h02;
    localparam logic [OP_W-1:0] OP_JAL   = 6'h03;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
    localparam logic [OP_W-1:0] FN_JR    = 6'h08;
    localparam logic [OP_W-1:0] FN_RTE   = 6'h13;

    localparam logic [SRC_W-1:0] PCSRC_JUMP   = 3'b000;
    localparam logic [SRC_W-1:0] PCSRC_EPC    = 3'b001;
    localparam logic [SRC_W-1:0] PCSRC_ALU    = 3'b010;
    localparam logic [SRC_W-1:0] PCSRC_ALUOUT = 3'b011;
    localparam logic [SRC_W-1:0] PCSRC_EXCVEC = 3'b100;

    localparam logic [2:0] ALUOP_PASSA = 3'b000;
    localparam logic [2:0] ALUOP_SUB   = 3'b010;

    localparam logic [1:0] SRCA_PC   = 2'b00;
    localparam logic [1:0] SRCA_A    = 2'b01;
    localparam logic [1:0] SRCB_B    = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;

    localparam logic [1:0] EXC_NONE   = 2'b00;
    localparam logic [1:0] EXC_OPCODE = 2'b01;
    localparam logic [1:0] EXC_OVF    = 2'b10;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_BR_CMP,
        ST_JUMP,
        ST_JR,
        ST_RTE,
        ST_EXC_SAVE,
        ST_EXC_READ,
        ST_EXC_WAIT,
        ST_EXC_LOAD,
        ST_DONE
    } state_t;

    typedef enum logic [2:0] {
        CLS_BEQ,
        CLS_BNE,
        CLS_J,
        CLS_JAL,
        CLS_JR,
        CLS_RTE,
        CLS_EXC_OVF,
        CLS_EXC_OPC
    } pc_class_t;

    function automatic state_t class_entry_state(input pc_class_t cls);
        case (cls)
            CLS_BEQ, CLS_BNE: class_entry_state = ST_BR_CMP;
            CLS_J, CLS_JAL:   class_entry_state = ST_JUMP;
            CLS_JR:           class_entry_state = ST_JR;
            CLS_RTE:          class_entry_state = ST_RTE;
            default:          class_entry_state = ST_EXC_SAVE;
        endcase
    endfunction

endpackage

// File: rtl/pc_flow_sequencer_class_decode.sv
// Combinational classifier: maps a sampled instruction plus pending exception flags onto
// the flow the sequencer must run. Overflow beats invalid opcode beats the PC class.
module pc_flow_sequencer_class_decode
    import pc_flow_sequencer_pkg::*;
(
    input  logic [OP_W-1:0] opcode,
    input  logic [OP_W-1:0] funct,
    input  logic            exc_overflow,
    input  logic            exc_opcode,
    output pc_class_t       pc_class
);

    always_comb begin
        pc_class = CLS_EXC_OPC;
        if (exc_overflow) begin
            pc_class = CLS_EXC_OVF;
        end else if (!exc_opcode) begin
            case (opcode)
                OP_BEQ: pc_class = CLS_BEQ;
                OP_BNE: pc_class = CLS_BNE;
                OP_J:   pc_class = CLS_J;
                OP_JAL: pc_class = CLS_JAL;
                OP_RTYPE: begin
                    // Any other R-type funct reaching here is not a PC flow.
                    if (funct == FN_JR) begin
                        pc_class = CLS_JR;
                    end else if (funct == FN_RTE) begin
                        pc_class = CLS_RTE;
                    end
                end
                default: pc_class = CLS_EXC_OPC;
            endcase
        end
    end

endmodule

// File: rtl/pc_flow_sequencer.sv
// PC-source sequencer: runs branch, jump, jr, rte and exception-entry flows on request from
// main control, driving the PC/EPC write enables and ALU/memory selects, then pulses done.
module pc_flow_sequencer
    import pc_flow_sequencer_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [OP_W-1:0]  opcode,
    input  logic [OP_W-1:0]  funct,
    input  logic             exc_overflow,
    input  logic             exc_opcode,
    input  logic             zero,
    output logic [SRC_W-1:0] PCsource,
    output logic             PCWrite,
    output logic             EPCWrite,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [2:0]       ALUOp,
    output logic             MemRead,
    output logic [1:0]       exc_addr_sel,
    output logic             ra_write,
    output logic             busy,
    output logic             done
);

    state_t            state_q, state_d;
    pc_class_t         cls_q, cls_d, start_cls;
    logic [SRC_W-1:0]  pc_source_q, pc_source_d;
    logic              pc_write_q, pc_write_d;
    logic              br_cmp_q, br_cmp_d;
    logic              epc_write_q, epc_write_d;
    logic [1:0]        alu_src_a_q, alu_src_a_d;
    logic [1:0]        alu_src_b_q, alu_src_b_d;
    logic [2:0]        alu_op_q, alu_op_d;
    logic              mem_read_q, mem_read_d;
    logic [1:0]        exc_addr_sel_q, exc_addr_sel_d;
    logic              ra_write_q, ra_write_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    pc_flow_sequencer_class_decode u_class_decode (
        .opcode       (opcode),
        .funct        (funct),
        .exc_overflow (exc_overflow),
        .exc_opcode   (exc_opcode),
        .pc_class     (start_cls)
    );

    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cls_d   = start_cls;
                    state_d = class_entry_state(start_cls);
                end
            end
            ST_BR_CMP, ST_JUMP, ST_JR, ST_RTE, ST_EXC_LOAD: state_d = ST_DONE;
            ST_EXC_SAVE: state_d = ST_EXC_READ;
            ST_EXC_READ: state_d = ST_EXC_WAIT;
            ST_EXC_WAIT: state_d = ST_EXC_LOAD;
            default:     state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the upcoming state so they register alongside it.
    always_comb begin
        pc_source_d    = PCSRC_JUMP;
        pc_write_d     = 1'b0;
        br_cmp_d       = 1'b0;
        epc_write_d    = 1'b0;
        alu_src_a_d    = SRCA_PC;
        alu_src_b_d    = SRCB_B;
        alu_op_d       = ALUOP_PASSA;
        mem_read_d     = 1'b0;
        exc_addr_sel_d = EXC_NONE;
        ra_write_d     = 1'b0;
        busy_d         = (state_d != ST_IDLE);
        done_d         = (state_d == ST_DONE);
        case (state_d)
            ST_BR_CMP: begin
                alu_src_a_d = SRCA_A;
                alu_src_b_d = SRCB_B;
                alu_op_d    = ALUOP_SUB;
                pc_source_d = PCSRC_ALUOUT;
                br_cmp_d    = 1'b1;
            end
            ST_JUMP: begin
                pc_source_d = PCSRC_JUMP;
                pc_write_d  = 1'b1;
                ra_write_d  = (cls_d == CLS_JAL);
            end
            ST_JR: begin
                alu_src_a_d = SRCA_A;
                alu_op_d    = ALUOP_PASSA;
                pc_source_d = PCSRC_ALU;
                pc_write_d  = 1'b1;
            end
            ST_RTE: begin
                pc_source_d = PCSRC_EPC;
                pc_write_d  = 1'b1;
            end
            ST_EXC_SAVE: begin
                alu_src_a_d = SRCA_PC;
                alu_src_b_d = SRCB_FOUR;
                alu_op_d    = ALUOP_SUB;
                epc_write_d = 1'b1;
            end
            ST_EXC_READ, ST_EXC_WAIT: begin
                mem_read_d     = 1'b1;
                exc_addr_sel_d = (cls_d == CLS_EXC_OVF) ? EXC_OVF : EXC_OPCODE;
            end
            ST_EXC_LOAD: begin
                pc_source_d = PCSRC_EXCVEC;
                pc_write_d  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            cls_q          <= CLS_BEQ;
            pc_source_q    <= PCSRC_JUMP;
            pc_write_q     <= 1'b0;
            br_cmp_q       <= 1'b0;
            epc_write_q    <= 1'b0;
            alu_src_a_q    <= SRCA_PC;
            alu_src_b_q    <= SRCB_B;
            alu_op_q       <= ALUOP_PASSA;
            mem_read_q     <= 1'b0;
            exc_addr_sel_q <= EXC_NONE;
            ra_write_q     <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            cls_q          <= cls_d;
            pc_source_q    <= pc_source_d;
            pc_write_q     <= pc_write_d;
            br_cmp_q       <= br_cmp_d;
            epc_write_q    <= epc_write_d;
            alu_src_a_q    <= alu_src_a_d;
            alu_src_b_q    <= alu_src_b_d;
            alu_op_q       <= alu_op_d;
            mem_read_q     <= mem_read_d;
            exc_addr_sel_q <= exc_addr_sel_d;
            ra_write_q     <= ra_write_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
        end
    end

    // The branch decision is the one output that must follow the live ALU zero flag.
    assign PCWrite      = pc_write_q | (br_cmp_q & (zero ^ (cls_q == CLS_BNE)));
    assign PCsource     = pc_source_q;
    assign EPCWrite     = epc_write_q;
    assign ALUSrcA      = alu_src_a_q;
    assign ALUSrcB      = alu_src_b_q;
    assign ALUOp        = alu_op_q;
    assign MemRead      = mem_read_q;
    assign exc_addr_sel = exc_addr_sel_q;
    assign ra_write     = ra_write_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_pc_flow_sequencer.sv
// Testbench for pc_flow_sequencer: directed flows from the block's test list followed by
// randomized traffic, all checked cycle by cycle against a flow-table reference model.
module tb_pc_flow_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       exc_overflow;
    logic       exc_opcode;
    logic       zero;
    logic [2:0] PCsource;
    logic       PCWrite;
    logic       EPCWrite;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUOp;
    logic       MemRead;
    logic [1:0] exc_addr_sel;
    logic       ra_write;
    logic       busy;
    logic       done;

    int checkCount = 0;
    int errorCount = 0;

    // Reference model: which flow is running and how far into it we are (1 = first cycle after start).
    localparam int K_IDLE = 0;
    localparam int K_BEQ  = 1;
    localparam int K_BNE  = 2;
    localparam int K_J    = 3;
    localparam int K_JAL  = 4;
    localparam int K_JR   = 5;
    localparam int K_RTE  = 6;
    localparam int K_OVF  = 7;
    localparam int K_OPC  = 8;

    int mKind = K_IDLE;
    int mStep = 0;

    logic [5:0] opTable [6] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h3F};
    logic [5:0] fnTable [4] = '{6'h08, 6'h13, 6'h20, 6'h00};

    pc_flow_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .opcode       (opcode),
        .funct        (funct),
        .exc_overflow (exc_overflow),
        .exc_opcode   (exc_opcode),
        .zero         (zero),
        .PCsource     (PCsource),
        .PCWrite      (PCWrite),
        .EPCWrite     (EPCWrite),
        .ALUSrcA      (ALUSrcA),
        .ALUSrcB      (ALUSrcB),
        .ALUOp        (ALUOp),
        .MemRead      (MemRead),
        .exc_addr_sel (exc_addr_sel),
        .ra_write     (ra_write),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h (time %0t, flow %0d step %0d)",
                     tag, observed, expected, $time, mKind, mStep);
        end
    endtask

    function automatic int classify(input logic [5:0] op, input logic [5:0] fn, input logic ovf, input logic opc);
        if (ovf) return K_OVF;
        if (opc) return K_OPC;
        if (op == 6'h04) return K_BEQ;
        if (op == 6'h05) return K_BNE;
        if (op == 6'h02) return K_J;
        if (op == 6'h03) return K_JAL;
        if (op == 6'h00 && fn == 6'h08) return K_JR;
        if (op == 6'h00 && fn == 6'h13) return K_RTE;
        return K_OPC;
    endfunction

    function automatic int flowLength(input int kind);
        return (kind == K_OVF || kind == K_OPC) ? 5 : 2;
    endfunction

    // Expected outputs for the current model position, given the live zero flag.
    task automatic checkAll(input logic z);
        logic [2:0] ePcSrc  = 3'b000;
        logic       ePcW    = 1'b0;
        logic       eEpcW   = 1'b0;
        logic [1:0] eSrcA   = 2'b00;
        logic [1:0] eSrcB   = 2'b00;
        logic [2:0] eAluOp  = 3'b000;
        logic       eMemRd  = 1'b0;
        logic [1:0] eExcSel = 2'b00;
        logic       eRa     = 1'b0;
        logic       eBusy   = (mKind != K_IDLE);
        logic       eDone   = 1'b0;
        if (mKind != K_IDLE) begin
            if (mStep == flowLength(mKind)) begin
                eDone = 1'b1;
            end else if (mKind == K_OVF || mKind == K_OPC) begin
                if (mStep == 1) begin
                    eSrcA = 2'b00; eSrcB = 2'b01; eAluOp = 3'b010; eEpcW = 1'b1;
                end else if (mStep == 2 || mStep == 3) begin
                    eMemRd = 1'b1;
                    eExcSel = (mKind == K_OVF) ? 2'b10 : 2'b01;
                end else begin
                    ePcSrc = 3'b100; ePcW = 1'b1;
                end
            end else begin
                case (mKind)
                    K_BEQ, K_BNE: begin
                        eSrcA = 2'b01; eSrcB = 2'b00; eAluOp = 3'b010; ePcSrc = 3'b011;
                        ePcW = (mKind == K_BEQ) ? z : !z;
                    end
                    K_J, K_JAL: begin
                        ePcSrc = 3'b000; ePcW = 1'b1; eRa = (mKind == K_JAL);
                    end
                    K_JR: begin
                        eSrcA = 2'b01; eAluOp = 3'b000; ePcSrc = 3'b010; ePcW = 1'b1;
                    end
                    default: begin
                        ePcSrc = 3'b001; ePcW = 1'b1;
                    end
                endcase
            end
        end
        checkOutput("PCsource", 32'(PCsource), 32'(ePcSrc));
        checkOutput("PCWrite", 32'(PCWrite), 32'(ePcW));
        checkOutput("EPCWrite", 32'(EPCWrite), 32'(eEpcW));
        checkOutput("ALUSrcA", 32'(ALUSrcA), 32'(eSrcA));
        checkOutput("ALUSrcB", 32'(ALUSrcB), 32'(eSrcB));
        checkOutput("ALUOp", 32'(ALUOp), 32'(eAluOp));
        checkOutput("MemRead", 32'(MemRead), 32'(eMemRd));
        checkOutput("exc_addr_sel", 32'(exc_addr_sel), 32'(eExcSel));
        checkOutput("ra_write", 32'(ra_write), 32'(eRa));
        checkOutput("busy", 32'(busy), 32'(eBusy));
        checkOutput("done", 32'(done), 32'(eDone));
        checkOutput("pcw_epcw_exclusive", 32'(PCWrite & EPCWrite), 32'd0);
    endtask

    // One clock cycle: drive inputs after the falling edge, check, then advance the model.
    task automatic applyStimulus(input logic rst, input logic st, input logic [5:0] op, input logic [5:0] fn,
                                 input logic ovf, input logic opc, input logic z);
        @(negedge clk);
        reset = rst; start = st; opcode = op; funct = fn;
        exc_overflow = ovf; exc_opcode = opc; zero = z;
        #1;
        checkAll(z);
        if (rst) begin
            mKind = K_IDLE;
            mStep = 0;
        end else if (mKind == K_IDLE) begin
            if (st) begin
                mKind = classify(op, fn, ovf, opc);
                mStep = 1;
            end
        end else if (mStep == flowLength(mKind)) begin
            mKind = K_IDLE;
            mStep = 0;
        end else begin
            mStep++;
        end
    endtask

    task automatic idleCycles(input int n, input logic z);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 6'h00, 6'h00, 1'b0, 1'b0, z);
    endtask

    task automatic runFlow(input logic [5:0] op, input logic [5:0] fn, input logic ovf, input logic opc, input logic z);
        applyStimulus(1'b0, 1'b1, op, fn, ovf, opc, z);
        idleCycles(6, z);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; opcode = '0; funct = '0;
        exc_overflow = 1'b0; exc_opcode = 1'b0; zero = 1'b0;
        repeat (2) @(posedge clk);

        // Reset state, then every flow from the test list.
        applyStimulus(1'b1, 1'b0, 6'h00, 6'h00, 1'b0, 1'b0, 1'b0);
        idleCycles(1, 1'b0);
        runFlow(6'h04, 6'h00, 1'b0, 1'b0, 1'b1);
        runFlow(6'h04, 6'h00, 1'b0, 1'b0, 1'b0);
        runFlow(6'h05, 6'h00, 1'b0, 1'b0, 1'b0);
        runFlow(6'h05, 6'h00, 1'b0, 1'b0, 1'b1);
        runFlow(6'h02, 6'h00, 1'b0, 1'b0, 1'b0);
        runFlow(6'h03, 6'h00, 1'b0, 1'b0, 1'b0);
        runFlow(6'h00, 6'h08, 1'b0, 1'b0, 1'b0);
        runFlow(6'h00, 6'h13, 1'b0, 1'b0, 1'b0);
        runFlow(6'h04, 6'h00, 1'b1, 1'b1, 1'b0);
        runFlow(6'h3F, 6'h00, 1'b0, 1'b0, 1'b0);
        runFlow(6'h00, 6'h2A, 1'b0, 1'b0, 1'b0);

        // Start pulses inside busy windows must be ignored.
        applyStimulus(1'b0, 1'b1, 6'h02, 6'h00, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 6'h3F, 6'h00, 1'b1, 1'b0, 1'b0);
        idleCycles(3, 1'b0);
        applyStimulus(1'b0, 1'b1, 6'h00, 6'h00, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 6'h04, 6'h00, 1'b1, 1'b0, 1'b1);
        idleCycles(3, 1'b1);

        // Reset during EXC_READ aborts; a start straight afterwards is accepted.
        applyStimulus(1'b0, 1'b1, 6'h00, 6'h00, 1'b1, 1'b0, 1'b0);
        idleCycles(1, 1'b0);
        applyStimulus(1'b1, 1'b0, 6'h00, 6'h00, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 6'h03, 6'h00, 1'b0, 1'b0, 1'b0);
        idleCycles(3, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            logic       rRst = ($urandom_range(99) < 2);
            logic       rSt  = ($urandom_range(99) < 45);
            logic [5:0] rOp  = ($urandom_range(9) < 8) ? opTable[$urandom_range(5)] : 6'($urandom);
            logic [5:0] rFn  = fnTable[$urandom_range(3)];
            logic       rOvf = ($urandom_range(99) < 10);
            logic       rOpc = ($urandom_range(99) < 10);
            logic       rZ   = 1'($urandom);
            applyStimulus(rRst, rSt, rOp, rFn, rOvf, rOpc, rZ);
        end
        idleCycles(6, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
